// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-look-ahead adder/subtractor: 4-bit CLA groups, GROUPS_PER_STAGE groups per
// stage, carry and unconsumed operand slices registered between stages, valid/ready streaming.
module pipelined_cla_addsub #(
  parameter int WIDTH            = 32,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);
  localparam int SW         = 4 * GROUPS_PER_STAGE;
  localparam int NUM_STAGES = WIDTH / SW;

  logic advance;

  // One 4-bit look-ahead group; returns {carry out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] p, g;
    logic       c1, c2, c3, c4;
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ {c3, c2, c1, c0}};
  endfunction

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO  = k * SW;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]   a_i, b_i;
    logic             c_i, v_i;
    logic [SW-1:0]    slice;
    logic [LO+SW-1:0] s_cat;
    logic             c_o;
    logic [4:0]       grp;

    // Operands of the first stage come straight from the ports, later ones from the skew registers.
    if (k == 0) begin : g_src
      assign a_i   = in1;
      assign b_i   = op_sub ? ~in2 : in2;
      assign c_i   = op_sub | cin;
      assign v_i   = in_valid;
      assign s_cat = slice;
    end else begin : g_src
      assign a_i   = g_stage[k-1].g_reg.a_q;
      assign b_i   = g_stage[k-1].g_reg.b_q;
      assign c_i   = g_stage[k-1].g_reg.c_q;
      assign v_i   = g_stage[k-1].g_reg.v_q;
      assign s_cat = {slice, g_stage[k-1].g_reg.s_q};
    end

    always_comb begin
      slice = '0;
      grp   = '0;
      c_o   = c_i;
      for (int g = 0; g < GROUPS_PER_STAGE; g++) begin
        grp             = cla4(a_i[4*g +: 4], b_i[4*g +: 4], c_o);
        slice[4*g +: 4] = grp[3:0];
        c_o             = grp[4];
      end
    end

    if (k < NUM_STAGES - 1) begin : g_reg
      logic [REM-SW-1:0] a_q, b_q;
      logic [LO+SW-1:0]  s_q;
      logic              c_q, v_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= v_i;
          c_q <= c_o;
          a_q <= a_i[REM-1:SW];
          b_q <= b_i[REM-1:SW];
          s_q <= s_cat;
        end
      end
    end else begin : g_out
      // Carry into the MSB is recovered from the MSB sum bit: s ^ a ^ b'.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          out       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (advance) begin
          out_valid <= v_i;
          out       <= v_i ? s_cat : '0;
          cout      <= v_i & c_o;
          ovf       <= v_i & (c_o ^ slice[SW-1] ^ a_i[REM-1] ^ b_i[REM-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub: arithmetic reference model with per-op latency
// tracking, checked every cycle, plus directed literal checks.
module tb_pipelined_cla_addsub;
  localparam int WIDTH      = 32;
  localparam int NUM_STAGES = 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, cin, op_sub;
  logic             out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] in1, in2, out;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    int               rem;
  } exp_t;

  exp_t q[$];
  int   total   = 0;
  int   passed  = 0;
  bit   started = 1'b0;
  logic exp_v;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(WIDTH), .GROUPS_PER_STAGE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .cout(cout), .ovf(ovf)
  );

  // Expected result of one operation straight from the arithmetic definition.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s);
    exp_t           e;
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   sum;
    bp    = s ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, (s ? 1'b1 : c)};
    e.res = sum[WIDTH-1:0];
    e.c   = sum[WIDTH];
    e.v   = (a[WIDTH-1] == bp[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    e.rem = NUM_STAGES - 1;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] randOperand();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return $urandom;
    endcase
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, want, $time);
  endtask

  // Model state is advanced at each falling edge using the inputs the next rising edge will see.
  always @(negedge clk) begin
    exp_v = (q.size() > 0) && (q[0].rem == 0);
    if (started) begin
      compare("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
      compare("in_ready", {63'd0, in_ready}, {63'd0, (!exp_v || out_ready)});
      if (exp_v) begin
        compare("out", {32'd0, out}, {32'd0, q[0].res});
        compare("cout", {63'd0, cout}, {63'd0, q[0].c});
        compare("ovf", {63'd0, ovf}, {63'd0, q[0].v});
      end else begin
        compare("out_idle_zero", {32'd0, out}, 64'd0);
      end
    end
    if (rst) begin
      q.delete();
      started = 1'b1;
    end else if (started) begin
      if (exp_v && out_ready) void'(q.pop_front());
      if (!exp_v || out_ready) begin
        foreach (q[i]) if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
        if (in_valid) q.push_back(model(in1, in2, cin, op_sub));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the operands.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input logic s);
    int guard = 0;
    in1 = a; in2 = b; cin = c; op_sub = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) compare("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [WIDTH-1:0] eo,
                             input logic ec, input logic eovf);
    compare({name, "_valid"}, {63'd0, out_valid}, {63'd0, ev});
    compare({name, "_out"}, {32'd0, out}, {32'd0, eo});
    compare({name, "_cout"}, {63'd0, cout}, {63'd0, ec});
    compare({name, "_ovf"}, {63'd0, ovf}, {63'd0, eovf});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in1 = 32'hDEADBEEF; in2 = 32'h12345678;
    cin = 1'b1; op_sub = 1'b0; out_ready = 1'b1;

    // Reset held with in_valid asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    compare("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;

    // Full carry ripple across all stages
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare("carry_chain_early", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    checkOutput("carry_chain", 1'b1, 32'h00000000, 1'b1, 1'b0);
    @(negedge clk);
    compare("carry_chain_once", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Subtraction with overflow, then with borrow (cin must be ignored)
    applyStimulus(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    applyStimulus(32'h00000005, 32'h00000007, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("sub_ovf", 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("sub_borrow", 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Back-to-back streaming
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] a;
      a = randOperand();
      applyStimulus(a, ($urandom_range(0, 1) != 0) ? ~a : randOperand(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (6) @(posedge clk);
    #1;

    // Back-pressure in the middle of a 6-op stream
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          compare("bp_stall_in_ready", {63'd0, in_ready}, 64'd0);
          compare("bp_stall_valid", {63'd0, out_valid}, 64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Reset while three ops are in flight
    applyStimulus(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    applyStimulus(32'h33333333, 32'h44444444, 1'b0, 1'b1);
    applyStimulus(32'h55555555, 32'h66666666, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compare("flush_quiet", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare("after_flush_early", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    checkOutput("after_flush", 1'b1, 32'h23456789, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Random traffic with random back-pressure
    repeat (300) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in1       = randOperand();
      in2       = ($urandom_range(0, 3) == 0) ? ~in1 : randOperand();
      cin       = 1'($urandom_range(0, 1));
      op_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
